// File: rtl/rr_mux4_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux4_arbiter_pkg
// Brief    : Shared constants, state type and round-robin pick helper.
// Revision : 1.0
// ============================================================================
package rr_mux4_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int REQ_W   = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Returns {found, idx}. Scanning from the far end down lets the
    // nearest valid requester after ptr overwrite any farther one.
    function automatic logic [REQ_W:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [REQ_W-1:0]   ptr
    );
        logic [REQ_W:0]   result;
        logic [REQ_W-1:0] idx;
        result = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + REQ_W'(k);
            if (valid[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux4_arbiter_mux4.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux4_arbiter_mux4
// Brief    : Plain N-bit 4:1 multiplexer driven by a 2-bit select.
// Revision : 1.0
// ============================================================================
module rr_mux4_arbiter_mux4 #(
    parameter int N = 32
) (
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic [1:0]   s,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        case (s)
            2'd0: y = in0;
            2'd1: y = in1;
            2'd2: y = in2;
            2'd3: y = in3;
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux4_arbiter
// Brief    : Round-robin arbiter with burst lock sharing one 4:1 data path
//            into a single registered output stage.
// Revision : 1.0
// ============================================================================
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_lock,
    input  logic [N-1:0]       in0,
    input  logic [N-1:0]       in1,
    input  logic [N-1:0]       in2,
    input  logic [N-1:0]       in3,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               out_valid,
    output logic [N-1:0]       out_data,
    input  logic               out_ready,
    output logic [REQ_W-1:0]   out_grant,
    output logic               locked
);

    arb_state_t       r_state;
    logic [REQ_W-1:0] r_ptr;
    logic [REQ_W-1:0] r_lock_owner;
    logic             r_out_valid;
    logic [N-1:0]     r_out_data;
    logic [REQ_W-1:0] r_out_grant;

    logic [REQ_W:0]   w_pick;
    logic [REQ_W-1:0] w_sel;
    logic             w_found;
    logic             w_can_accept;
    logic             w_xfer;
    logic [N-1:0]     w_mux_y;

    assign w_can_accept = !r_out_valid || out_ready;
    assign w_pick       = rr_pick(req_valid, r_ptr);

    // While locked only the owner may win, even if others are waiting.
    always_comb begin
        w_sel   = w_pick[REQ_W-1:0];
        w_found = w_pick[REQ_W];
        if (r_state == LOCKED) begin
            w_sel   = r_lock_owner;
            w_found = req_valid[r_lock_owner];
        end
    end

    assign w_xfer    = !rst && w_can_accept && w_found;
    assign req_ready = w_xfer ? (NUM_REQ'(1) << w_sel) : '0;

    rr_mux4_arbiter_mux4 #(
        .N (N)
    ) u_mux4 (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .s   (w_sel),
        .y   (w_mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB;
            r_ptr        <= '0;
            r_lock_owner <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_grant  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_y;
            r_out_grant <= w_sel;
            r_ptr       <= w_sel + REQ_W'(1);
            if (req_lock[w_sel]) begin
                r_state      <= LOCKED;
                r_lock_owner <= w_sel;
            end else begin
                r_state <= ARB;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_grant = r_out_grant;
    assign locked    = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux4_arbiter
// Brief    : Directed vector table, reset corner case and randomized run
//            against a behavioural arbiter model.
// Revision : 1.0
// ============================================================================
module tb_rr_mux4_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_lock;
    logic [N-1:0] in_d [4];
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready;
    logic [1:0]   out_grant;
    logic         locked;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_mux4_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .in0       (in_d[0]),
        .in1       (in_d[1]),
        .in2       (in_d[2]),
        .in3       (in_d[3]),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_grant (out_grant),
        .locked    (locked)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       ord;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] g;
        logic       lk;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] v, input logic [3:0] l, input logic ord,
                                input logic [3:0] rdy, input logic ov, input logic [1:0] g,
                                input logic lk);
        vec_t t;
        t.v = v; t.l = l; t.ord = ord; t.rdy = rdy; t.ov = ov; t.g = g; t.lk = lk;
        tbl.push_back(t);
    endfunction

    task automatic step(input vec_t t);
        req_valid = t.v;
        req_lock  = t.l;
        out_ready = t.ord;
        @(negedge clk);
        chk("tbl_ready", 64'(req_ready), 64'(t.rdy));
        @(posedge clk);
        #1;
        chk("tbl_out_valid", 64'(out_valid), 64'(t.ov));
        chk("tbl_out_grant", 64'(out_grant), 64'(t.g));
        chk("tbl_locked",    64'(locked),    64'(t.lk));
        chk("tbl_out_data",  64'(out_data),  64'(in_d[t.g]));
    endtask

    // Behavioural model: state kept as plain integers and flags.
    int           m_ptr, m_owner, m_grant;
    bit           m_locked, m_ov;
    logic [N-1:0] m_data;

    function automatic void model_reset();
        m_ptr = 0; m_owner = 0; m_grant = 0;
        m_locked = 0; m_ov = 0; m_data = '0;
    endfunction

    function automatic logic [3:0] model_ready();
        int j;
        if (rst) return 4'b0;
        if (m_ov && !out_ready) return 4'b0;
        if (m_locked) return req_valid[m_owner] ? 4'(1 << m_owner) : 4'b0;
        for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (req_valid[j]) return 4'(1 << j);
        end
        return 4'b0;
    endfunction

    function automatic void model_update(input logic [3:0] rdy);
        int j;
        if (rst) begin
            model_reset();
        end else if (rdy != 0) begin
            j = 0;
            for (int i = 0; i < 4; i++) if (rdy[i]) j = i;
            m_data   = in_d[j];
            m_ov     = 1;
            m_grant  = j;
            m_ptr    = (j + 1) % 4;
            m_locked = req_lock[j];
            if (req_lock[j]) m_owner = j;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
    endfunction

    // Requesters hold valid, data and lock until accepted.
    task automatic gen_inputs(input logic [3:0] acc);
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                req_valid[i] = 1'b1;
                in_d[i]      = $urandom;
                req_lock[i]  = ($urandom_range(0, 2) == 0);
            end
        end
        out_ready = ($urandom_range(0, 3) != 0);
        rst       = ($urandom_range(0, 149) == 0);
    endtask

    initial begin
        logic [3:0] exp_rdy;

        for (int i = 0; i < 4; i++) in_d[i] = 32'hA0 + 32'(i);
        rst = 1'b1; req_valid = 4'b1111; req_lock = 4'b0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'h0);
        @(posedge clk); #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_data",  64'(out_data),  64'h0);
        chk("reset_out_grant", 64'(out_grant), 64'h0);
        chk("reset_locked",    64'(locked),    64'h0);
        rst = 1'b0;

        //   valid    lock     ord   ready    ov    g     lk
        add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);
        add(4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);
        add(4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);
        add(4'b1110, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1);
        add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++)
            add(4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
        add(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++)
            add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0);
        add(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1);

        foreach (tbl[i]) step(tbl[i]);

        // Reset while locked with a word held; requester 1 keeps its word up
        rst = 1'b1; req_valid = 4'b0010; req_lock = 4'b0010; out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(req_ready), 64'h0);
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_locked",    64'(locked),    64'h0);
        chk("midrst_out_grant", 64'(out_grant), 64'h0);
        rst = 1'b0; req_valid = 4'b1110; out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_ready", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        chk("postrst_out_grant", 64'(out_grant), 64'h1);
        chk("postrst_out_data",  64'(out_data),  64'hA1);
        chk("postrst_out_valid", 64'(out_valid), 64'h1);

        // Randomized run against the model
        rst = 1'b1; req_valid = 4'b0; req_lock = 4'b0;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        gen_inputs(4'b0);
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_rdy = model_ready();
            chk("rnd_ready",     64'(req_ready), 64'(exp_rdy));
            chk("rnd_out_valid", 64'(out_valid), 64'(m_ov));
            chk("rnd_out_grant", 64'(out_grant), 64'(m_grant));
            chk("rnd_locked",    64'(locked),    64'(m_locked));
            chk("rnd_out_data",  64'(out_data),  64'(m_data));
            @(posedge clk);
            model_update(exp_rdy);
            #1;
            gen_inputs(exp_rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares a single N-bit 4:1 select path between four valid/ready requesters.
- Generates the 2-bit select for a mux4 instance and registers the winning word into one output stage.
- Supports a per-requester lock so that one requester can hold the path for multi-word bursts.
- Sits in front of any single-ported shared resource (bus, write port, functional unit).

Parameters:
- N, 32, data width of each requester word and of the output.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  4  bit i = requester i presents a word
- req_lock  input  4  bit i = keep the grant on requester i after this word
- in0  input  N  requester 0 data
- in1  input  N  requester 1 data
- in2  input  N  requester 2 data
- in3  input  N  requester 3 data
- req_ready  output  4  one-hot or zero; bit i = word from requester i accepted this cycle
- out_valid  output  1  output register holds a word
- out_data  output  N  registered winning word
- out_ready  input  1  downstream consumes out_data when out_valid=1
- out_grant  output  2  index of the requester whose word is in out_data
- locked  output  1  arbiter is in LOCKED state

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_grant=0, locked=0.
  - Priority pointer ptr=0; state=ARB.
  - req_ready=0 while rst=1.
- Accept window: can_accept = !out_valid || out_ready. This is combinational, so the output stage sustains 1 word/cycle.
- ARB state selection:
  - sel = first i with req_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - If no req_valid bit is set, there is no selection.
- LOCKED state selection:
  - sel = lock_owner only, and only if req_valid[lock_owner]=1.
  - Other requesters stay at req_ready=0.
- req_ready[sel] = can_accept && a selection exists. All other bits are 0. This is combinational, with no loop through req_ready.
- Transfer (req_valid[sel] && req_ready[sel]) at the edge:
  - out_data <= in_sel, taken through the mux4 with s=sel.
  - out_valid <= 1; out_grant <= sel; ptr <= sel+1 mod 4 (wraps 3 -> 0).
  - If req_lock[sel]=1: state <= LOCKED, lock_owner <= sel.
  - If req_lock[sel]=0: state <= ARB.
- Drain without a new transfer: out_valid=1 && out_ready=1 gives out_valid <= 0. out_data and out_grant hold their values.
- Stall: out_valid=1 && out_ready=0 means out_data, out_grant and out_valid all hold, and req_ready=0.
- Simultaneous drain and transfer: out_valid stays 1 and out_data takes the new word, with no bubble.
- LOCKED with the owner's req_valid=0: the state stays LOCKED and no other requester is granted. This is intentional; the owner must finish the burst with lock=0.
- Latency: a word accepted at edge k is visible on out_data after edge k. Throughput is 1 word/cycle with out_ready held at 1.
- Fairness: in ARB state, a continuously asserting requester is granted within 4 transfers.
- Requester protocol (bench asserts this):
  - Once req_valid[i]=1, it stays 1 with stable data and lock until req_ready[i]=1.
- Reset mid-operation:
  - Any held word is dropped (out_valid=0).
  - LOCKED is abandoned and ptr returns to 0.
  - req_ready=0 in the reset cycle, so no transfer completes in that cycle.

Decomposition:
- Shared package:
  - NUM_REQ=4 and REQ_W=2 constants.
  - typedef enum logic {ARB, LOCKED} arb_state_t.
  - Function rr_pick(valid[3:0], ptr[1:0]) returning {found, idx[1:0]}.
- Sub-module: one mux4 #(.N(N)) instance selects in0..in3 using s=sel.
- Pointer, state and output register live in this block.

Test Plan:
- Reset, then req_valid=4'b1111 with in0..3=0xA0..0xA3, out_ready=1, no lock -> out_grant sequence 0,1,2,3,0 on consecutive cycles; out_data 0xA0,0xA1,0xA2,0xA3,0xA0; one req_ready bit per cycle.
- ptr=3 (after a grant to 2), req_valid=4'b0011 -> requester 0 granted (wrap-around), then 1.
- req_valid=4'b0101, requester 0 sends 3 words with lock=1,1,0 and requester 2 waiting -> grants 0,0,0, then 2; locked=1 for the two cycles after the first two transfers.
- out_valid=1 with out_ready=0 for 5 cycles while req_valid=4'b1000 -> req_ready=0 and out_data stable. Raise out_ready -> in3 accepted in the same cycle the old word drains, and out_valid stays 1.
- Assert rst while LOCKED and out_valid=1 -> next cycle out_valid=0, locked=0, out_grant=0. A following req_valid=4'b1110 is granted to requester 1 first (ptr=0 scan).
- req_valid=0 for 3 cycles after a single transfer -> out_valid drops to 0 after one out_ready cycle; req_ready stays 0.
